// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: stage handshakes, drawer pixel streams and VGA write port of the frame sequencer
interface frame_sequencer_if;
  logic       logic_done;
  logic       map_done;
  logic [8:0] map_x;
  logic [7:0] map_y;
  logic [5:0] map_colour;
  logic       map_write;
  logic       spr_done;
  logic [8:0] spr_x;
  logic [7:0] spr_y;
  logic [5:0] spr_colour;
  logic       spr_write;
  logic       logic_en;
  logic       map_en;
  logic       spr_en;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [5:0] vga_colour;
  logic       vga_write;
  modport master (
    input  logic_done, map_done, map_x, map_y, map_colour, map_write,
    input  spr_done, spr_x, spr_y, spr_colour, spr_write,
    output logic_en, map_en, spr_en, vga_x, vga_y, vga_colour, vga_write
  );
  modport slave (
    output logic_done, map_done, map_x, map_y, map_colour, map_write,
    output spr_done, spr_x, spr_y, spr_colour, spr_write,
    input  logic_en, map_en, spr_en, vga_x, vga_y, vga_colour, vga_write
  );
endinterface

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame update -> map -> sprite sequencing with VGA pixel mux; DRAW_TIMEOUT_EN adds a per-stage watchdog
module frame_sequencer #(
  parameter int FRAME_TICKS = 833333,
  parameter int TIMEOUT     = 131071
) (
  input  logic                  clock,
  input  logic                  reset,
  frame_sequencer_if.master     bus,
  output logic [7:0]            frame_missed,
  output logic                  stage_error
);
  localparam int CW = $clog2(FRAME_TICKS);
  typedef enum logic [1:0] {WAIT_FRAME, UPDATE, DRAW_MAP, DRAW_SPRITE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    missed_q, missed_d;
  logic          tick, done, expire, adv;
  // only the active stage's done is honoured
  always_comb begin
    done = (state_q == UPDATE && bus.logic_done) || (state_q == DRAW_MAP && bus.map_done) ||
           (state_q == DRAW_SPRITE && bus.spr_done);
  end
`ifdef DRAW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] scnt_q, scnt_d;
  logic          err_q, err_d;
  // watchdog: a stage that has run TIMEOUT cycles without done is forced onward
  always_comb begin
    expire = state_q != WAIT_FRAME && !done && scnt_q == TW'(TIMEOUT - 1);
    err_d  = err_q | expire;
    scnt_d = (state_q == WAIT_FRAME || done || expire) ? '0 : scnt_q + 1'b1;
  end
  // watchdog counter and sticky error flag
  always_ff @(posedge clock) begin
    scnt_q <= reset ? '0 : scnt_d;
    err_q  <= reset ? 1'b0 : err_d;
  end
  assign stage_error = err_q;
`else
  assign expire      = 1'b0;
  assign stage_error = 1'b0;
`endif
  // frame tick, stage advance and overrun bookkeeping
  always_comb begin
    tick     = cnt_q == CW'(FRAME_TICKS - 1);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    adv      = done | expire;
    state_d  = state_q == WAIT_FRAME ? ((tick || pend_q) ? UPDATE : WAIT_FRAME) :
               adv ? state_t'(state_q + 2'd1) : state_q;
    pend_d   = state_q != WAIT_FRAME && (pend_q || tick);
    missed_d = (tick && state_q != WAIT_FRAME && missed_q != 8'hFF) ? missed_q + 8'd1 : missed_q;
  end
  // sequencer state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= WAIT_FRAME;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
    end
  end
  // Moore enables and zero-latency pixel mux from the active drawer
  always_comb begin
    bus.logic_en   = state_q == UPDATE;
    bus.map_en     = state_q == DRAW_MAP;
    bus.spr_en     = state_q == DRAW_SPRITE;
    bus.vga_x      = state_q == DRAW_MAP ? bus.map_x : state_q == DRAW_SPRITE ? bus.spr_x : '0;
    bus.vga_y      = state_q == DRAW_MAP ? bus.map_y : state_q == DRAW_SPRITE ? bus.spr_y : '0;
    bus.vga_colour = state_q == DRAW_MAP ? bus.map_colour : state_q == DRAW_SPRITE ? bus.spr_colour : '0;
    bus.vga_write  = state_q == DRAW_MAP ? bus.map_write : state_q == DRAW_SPRITE && bus.spr_write;
  end
  assign frame_missed = missed_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized drawers against a behavioural frame/stage model plus directed literal checks
module tb_frame_sequencer;
  localparam int FT = 100;
  localparam int TO = 20;
  localparam int NEVER = 1000000;
  logic clock = 0, reset = 1;
  logic [7:0] frame_missed;
  logic stage_error;
  frame_sequencer_if bus();
  frame_sequencer #(.FRAME_TICKS(FT), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus), .frame_missed(frame_missed), .stage_error(stage_error)
  );
  always #5 clock = ~clock;
  int total = 0, bad = 0;
  int dl = NEVER, dm = NEVER, ds = NEVER;
  bit rand_mode = 0, fixed_pix = 0;
  int m_stage = 0, m_pend = 0, m_missed = 0, m_err = 0, m_t = 0, m_scnt = 0;
  bit m_ok = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic cur(input int sel);
    return sel == 0 ? bus.logic_en : sel == 1 ? bus.map_en : bus.spr_en;
  endfunction
  task automatic wait_sig(input int sel, input logic v, input int budget);
    int n = 0;
    while (cur(sel) !== v && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (cur(sel) !== v) chk($sformatf("wait_bound_sel%0d", sel), {31'd0, cur(sel)}, {31'd0, v});
  endtask
  task automatic do_reset();
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
  endtask
  function automatic int pick();
    return $urandom_range(0, 9) == 0 ? int'($urandom_range(60, 130)) : int'($urandom_range(1, 12));
  endfunction
  // drawers: each done rises once its enable has been high for the chosen number of cycles
  initial begin
    int cl = 0, cm = 0, cs = 0;
    bus.logic_done = 0; bus.map_done = 0; bus.spr_done = 0;
    bus.map_x = 0; bus.map_y = 0; bus.map_colour = 0; bus.map_write = 0;
    bus.spr_x = 0; bus.spr_y = 0; bus.spr_colour = 0; bus.spr_write = 0;
    forever begin
      @(posedge clock); #1;
      cl = bus.logic_en ? cl + 1 : 0;
      cm = bus.map_en ? cm + 1 : 0;
      cs = bus.spr_en ? cs + 1 : 0;
      if (rand_mode) begin
        if (cl == 1) dl = pick();
        if (cm == 1) dm = pick();
        if (cs == 1) ds = pick();
      end
      bus.logic_done = bus.logic_en && cl >= dl;
      bus.map_done = bus.map_en && cm >= dm;
      bus.spr_done = bus.spr_en && cs >= ds;
      bus.map_x = fixed_pix ? 9'd5 : 9'($urandom);
      bus.map_y = fixed_pix ? 8'd7 : 8'($urandom);
      bus.map_colour = fixed_pix ? 6'h2A : 6'($urandom);
      bus.map_write = fixed_pix ? 1'b1 : 1'($urandom);
      bus.spr_x = 9'($urandom);
      bus.spr_y = 8'($urandom);
      bus.spr_colour = 6'($urandom);
      bus.spr_write = 1'($urandom);
    end
  end
  // reference model: stage index 0=idle 1=update 2=map 3=sprite, time since reset gives the frame tick
  initial forever begin
    int prev;
    bit tk, dn, ex;
    @(posedge clock);
    if (reset) begin
      m_stage = 0; m_pend = 0; m_missed = 0; m_err = 0; m_t = 0; m_scnt = 0; m_ok = 1;
    end else if (m_ok) begin
      tk = m_t == FT - 1;
      m_t = (m_t + 1) % FT;
      dn = (m_stage == 1 && bus.logic_done) || (m_stage == 2 && bus.map_done) || (m_stage == 3 && bus.spr_done);
      ex = 0;
`ifdef DRAW_TIMEOUT_EN
      ex = m_stage != 0 && !dn && m_scnt == TO - 1;
      if (ex) m_err = 1;
`endif
      prev = m_stage;
      if (m_stage == 0) begin
        if (tk || m_pend != 0) begin m_stage = 1; m_pend = 0; end
      end else begin
        if (tk) begin m_pend = 1; if (m_missed < 255) m_missed++; end
        if (dn || ex) m_stage = (m_stage + 1) % 4;
      end
      m_scnt = (m_stage != prev || m_stage == 0) ? 0 : m_scnt + 1;
    end
  end
  // every-cycle comparison of the DUT against the model
  initial forever begin
    @(negedge clock);
    if (m_ok) begin
      chk("logic_en", bus.logic_en, m_stage == 1);
      chk("map_en", bus.map_en, m_stage == 2);
      chk("spr_en", bus.spr_en, m_stage == 3);
      chk("vga_x", bus.vga_x, m_stage == 2 ? bus.map_x : m_stage == 3 ? bus.spr_x : 9'd0);
      chk("vga_y", bus.vga_y, m_stage == 2 ? bus.map_y : m_stage == 3 ? bus.spr_y : 8'd0);
      chk("vga_colour", bus.vga_colour, m_stage == 2 ? bus.map_colour : m_stage == 3 ? bus.spr_colour : 6'd0);
      chk("vga_write", bus.vga_write, m_stage == 2 ? bus.map_write : m_stage == 3 ? bus.spr_write : 1'b0);
      chk("frame_missed", frame_missed, m_missed);
      chk("stage_error", stage_error, m_err);
    end
  end
  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 0;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clock);
      chk($sformatf("first_frame_logic_en_c%0d", k), bus.logic_en, k == 100);
      if (k == 0 || k == 98 || k == 99) chk("first_frame_vga_write", bus.vga_write, 0);
    end
    dl = 3; dm = 11; ds = 6;
    repeat (80) @(negedge clock);
    chk("seq_idle_logic_en", bus.logic_en, 0);
    chk("seq_idle_map_en", bus.map_en, 0);
    chk("seq_idle_spr_en", bus.spr_en, 0);
    chk("seq_missed", frame_missed, 0);
    fixed_pix = 1;
    wait_sig(1, 1, 100);
    chk("mux_map_x", bus.vga_x, 5);
    chk("mux_map_y", bus.vga_y, 7);
    chk("mux_map_colour", bus.vga_colour, 'h2A);
    chk("mux_map_write", bus.vga_write, 1);
    wait_sig(2, 1, 50);
    chk("mux_spr_x", bus.vga_x, bus.spr_x);
    chk("mux_spr_write", bus.vga_write, bus.spr_write);
    wait_sig(2, 0, 50);
    chk("mux_idle_write", bus.vga_write, 0);
    chk("mux_idle_x", bus.vga_x, 0);
    fixed_pix = 0;
    rand_mode = 1;
    repeat (1500) @(negedge clock);
    rand_mode = 0;
    dl = 2; dm = NEVER; ds = 2;
    do_reset();
    wait_sig(1, 1, 200);
    do_reset();
    @(negedge clock);
    chk("midreset_map_en", bus.map_en, 0);
    chk("midreset_vga_write", bus.vga_write, 0);
    chk("midreset_missed", frame_missed, 0);
    chk("midreset_logic_en", bus.logic_en, 0);
`ifdef DRAW_TIMEOUT_EN
    dm = 2; ds = NEVER;
    wait_sig(2, 1, 300);
    begin
      int n = 0;
      while (bus.spr_en && n < 100) begin
        @(negedge clock);
        n++;
      end
      chk("timeout_cycles", n, TO);
    end
    chk("timeout_error", stage_error, 1);
    chk("timeout_idle", bus.logic_en | bus.map_en | bus.spr_en, 0);
    ds = 3;
    repeat (300) @(negedge clock);
    chk("timeout_sticky", stage_error, 1);
`else
    dl = 3; dm = NEVER; ds = 5;
    do_reset();
    wait_sig(1, 1, 200);
    repeat (250) @(negedge clock);
    chk("overrun_missed", frame_missed, 2);
    dm = 1;
    wait_sig(2, 1, 50);
    wait_sig(2, 0, 50);
    chk("overrun_wait_state", bus.logic_en, 0);
    @(negedge clock);
    chk("overrun_pending_update", bus.logic_en, 1);
    dm = NEVER;
    do_reset();
    wait_sig(1, 1, 200);
    repeat (26000) @(negedge clock);
    chk("saturate_missed", frame_missed, 255);
    chk("saturate_no_error", stage_error, 0);
    dm = 1;
    repeat (50) @(negedge clock);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
